alu_muldiv_ctrl: RTL and testbench

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

---
 rtl/alu_pkg.sv | 20 ++
 rtl/muldiv_iter.sv | 75 +++++++
 rtl/alu_muldiv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply/divide controller state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: latched operands plus a 2N-bit accumulator that performs
// one shift-add (multiply) or one restoring shift-subtract (divide) per step.
// Both operations start from {zeros, rda}. Multiply retires multiplier bits
// from the low half. Divide shifts dividend bits into the remainder half and
// quotient bits into the low half.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         stepMul_i,
  input  logic         stepDiv_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] accHi_o,
  output logic [N-1:0] accLo_o,
  output logic [N-1:0] opA_o,
  output logic         bZero_o
);

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opA_q, opA_d;
  logic [N-1:0]   opB_q, opB_d;
  logic [N:0]     mulSum;
  logic [N:0]     remShift;
  logic [N:0]     divTrial;

  // Next accumulator value for a load, a multiply step or a divide step
  always_comb begin
    acc_d    = acc_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    mulSum   = {1'b0, acc_q[2*N-1:N]};
    remShift = acc_q[2*N-1:N-1];
    divTrial = remShift - {1'b0, opB_q};
    if (acc_q[0]) begin
      mulSum = {1'b0, acc_q[2*N-1:N]} + {1'b0, opB_q};
    end
    if (load_i) begin
      acc_d = {{N{1'b0}}, a_i};
      opA_d = a_i;
      opB_d = b_i;
    end else if (stepMul_i) begin
      acc_d = {mulSum, acc_q[N-1:1]};
    end else if (stepDiv_i) begin
      if (!divTrial[N]) begin
        acc_d = {divTrial[N-1:0], acc_q[N-2:0], 1'b1};
      end else begin
        acc_d = {remShift[N-1:0], acc_q[N-2:0], 1'b0};
      end
    end
  end

  // Operand and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opA_q <= '0;
      opB_q <= '0;
    end else begin
      acc_q <= acc_d;
      opA_q <= opA_d;
      opB_q <= opB_d;
    end
  end

  assign accHi_o = acc_q[2*N-1:N];
  assign accLo_o = acc_q[N-1:0];
  assign opA_o   = opA_q;
  assign bZero_o = (opB_q == '0);

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Multiply/divide controller: accept handshake, iteration counter, state
// machine and the architectural Hi/Lo/div_zero registers. All outputs come
// straight from registers.
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] alu_decode,
  input  logic [N-1:0] rda,
  input  logic [N-1:0] rdx,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo,
  output logic         div_zero
);

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         isDiv_q, isDiv_d;
  logic         armed_q;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic         divZero_q, divZero_d;

  logic         decodeMul;
  logic         decodeDiv;
  logic         lastIter;
  logic         load;
  logic         stepMul;
  logic         stepDiv;
  logic         commit;
  logic [N-1:0] accHi;
  logic [N-1:0] accLo;
  logic [N-1:0] opA;
  logic         bZero;

  assign decodeMul = (alu_decode == M'(OP_MUL));
  assign decodeDiv = (alu_decode == M'(OP_DIV));
  assign lastIter  = (cnt_q == 6'(N - 1));

  muldiv_iter #(.N(N)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .stepMul_i (stepMul),
    .stepDiv_i (stepDiv),
    .a_i       (rda),
    .b_i       (rdx),
    .accHi_o   (accHi),
    .accLo_o   (accLo),
    .opA_o     (opA),
    .bZero_o   (bZero)
  );

  // Next state, counter and datapath strobes. A zero divisor is spotted on the
  // latched operand in the first DIV cycle and short-circuits straight to DONE.
  // A flush in DONE cannot retract that cycle's done, but blocks the commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isDiv_d = isDiv_q;
    load    = 1'b0;
    stepMul = 1'b0;
    stepDiv = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush && armed_q && (decodeMul || decodeDiv)) begin
          load    = 1'b1;
          cnt_d   = '0;
          isDiv_d = decodeDiv;
          state_d = decodeDiv ? DIV : MUL;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stepMul = 1'b1;
          cnt_d   = cnt_q + 6'd1;
          if (lastIter) state_d = DONE;
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else if (bZero) begin
          state_d = DONE;
        end else begin
          stepDiv = 1'b1;
          cnt_d   = cnt_q + 6'd1;
          if (lastIter) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        commit  = !flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // Architectural result update, only on a committed DONE cycle
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    divZero_d = divZero_q;
    if (commit) begin
      if (isDiv_q && bZero) begin
        hi_d      = opA;
        lo_d      = '1;
        divZero_d = 1'b1;
      end else if (isDiv_q) begin
        hi_d      = accHi;
        lo_d      = accLo;
        divZero_d = 1'b0;
      end else begin
        hi_d = accHi;
        lo_d = accLo;
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divZero_q <= divZero_d;
    end
  end

  // Stays low for the first edge after reset release, so a start arriving with the release is not taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: fixed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for reset release, flush, busy re-requests and mid-operation reset.
module tb_alu_muldiv_ctrl;
  import alu_pkg::*;

  localparam int N = 32;
  localparam int M = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [M-1:0] alu_decode;
  logic [N-1:0] rda;
  logic [N-1:0] rdx;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] Hi;
  logic [N-1:0] Lo;
  logic         div_zero;

  int vecCount  = 0;
  int missCount = 0;

  logic [N-1:0] mHi;
  logic [N-1:0] mLo;
  logic         mDz;
  int           mLat;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] eHi;
    logic [N-1:0] eLo;
    logic         eDz;
    int           eLat;
  } vec_t;

  vec_t vecs[8];

  alu_muldiv_ctrl #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_decode (alu_decode),
    .rda        (rda),
    .rdx        (rdx),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .Hi         (Hi),
    .Lo         (Lo),
    .div_zero   (div_zero)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model computed from plain arithmetic
  task automatic modelOp(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    if (op == OP_MUL) begin
      p    = (2*N)'(a) * (2*N)'(b);
      mHi  = p[2*N-1:N];
      mLo  = p[N-1:0];
      mLat = N;
    end else if (b == '0) begin
      mHi  = a;
      mLo  = '1;
      mDz  = 1'b1;
      mLat = 1;
    end else begin
      mHi  = a % b;
      mLo  = a / b;
      mDz  = 1'b0;
      mLat = N;
    end
  endtask

  // Called at a negedge: request, accept at the next edge, then watch for done
  task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                               output int doneAt);
    start      = 1'b1;
    alu_decode = op;
    rda        = a;
    rdx        = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rda   = $urandom;
    rdx   = $urandom;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    doneAt = -1;
    for (int k = 1; k <= N + 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      rda = $urandom;
      rdx = $urandom;
      if (done) begin
        doneAt = k;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] eHi, input logic [N-1:0] eLo, input logic eDz,
                             input int eLat);
    int doneAt;
    applyStimulus(op, a, b, doneAt);
    checkOutput("done_latency", 64'(doneAt), 64'(eLat));
    @(posedge clk);
    @(negedge clk);
    checkOutput("hi", 64'(Hi), 64'(eHi));
    checkOutput("lo", 64'(Lo), 64'(eLo));
    checkOutput("div_zero", 64'(div_zero), 64'(eDz));
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    mHi = eHi;
    mLo = eLo;
    mDz = eDz;
  endtask

  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int doneAt;
    int pulses;
    logic [3:0]     rop;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic [2*N-1:0] prod;

    vecs[0] = '{OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, N};
    vecs[1] = '{OP_DIV, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, N};
    vecs[2] = '{OP_DIV, 32'd55,        32'd0,         32'd55,        32'hFFFF_FFFF, 1'b1, 1};
    vecs[3] = '{OP_MUL, 32'd7,         32'd6,         32'd0,         32'd42,        1'b1, N};
    vecs[4] = '{OP_DIV, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0, N};
    vecs[5] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, N};
    vecs[6] = '{OP_DIV, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0, N};
    vecs[7] = '{OP_DIV, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, N};

    rst_n      = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    alu_decode = '0;
    rda        = '0;
    rdx        = '0;
    mHi = '0; mLo = '0; mDz = 1'b0; mLat = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(Hi), 64'd0);
    checkOutput("reset_lo", 64'(Lo), 64'd0);
    checkOutput("reset_div_zero", 64'(div_zero), 64'd0);

    // start arriving with reset release is ignored for one edge, then honoured
    rst_n      = 1'b1;
    start      = 1'b1;
    alu_decode = OP_MUL;
    rda        = 32'd3;
    rdx        = 32'd5;
    @(posedge clk);
    @(negedge clk);
    checkOutput("start_at_release_ignored", 64'(busy), 64'd0);
    runAndCheck(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, N);

    // Fixed vector table
    for (int i = 0; i < 8; i++) begin
      runAndCheck(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo, vecs[i].eDz, vecs[i].eLat);
    end

    // Non MUL/DIV opcodes are ignored
    start = 1'b1; alu_decode = OP_ADD; rda = 32'd1; rdx = 32'd2;
    @(posedge clk); @(negedge clk);
    checkOutput("op_add_ignored", 64'(busy), 64'd0);
    alu_decode = OP_SLT;
    @(posedge clk); @(negedge clk);
    checkOutput("op_slt_ignored", 64'(busy), 64'd0);

    // flush wins over start in the same cycle
    alu_decode = OP_MUL; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("flush_beats_start", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;
    checkOutput("ignored_keep_lo", 64'(Lo), 64'(mLo));

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = N'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      modelOp(rop, ra, rb);
      runAndCheck(rop, ra, rb, mHi, mLo, mDz, mLat);
    end

    // flush at iteration 10 of a MUL: no done, results untouched
    start = 1'b1; alu_decode = OP_MUL; rda = 32'd3; rdx = 32'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_to_idle", 64'(busy), 64'd0);
    countDone(N + 4, pulses);
    checkOutput("flush_no_done", 64'(pulses), 64'd0);
    checkOutput("flush_keep_hi", 64'(Hi), 64'(mHi));
    checkOutput("flush_keep_lo", 64'(Lo), 64'(mLo));
    checkOutput("flush_keep_dz", 64'(div_zero), 64'(mDz));

    // start held high while busy with changing operands: only the first runs
    a0 = $urandom; b0 = $urandom;
    start = 1'b1; alu_decode = OP_MUL; rda = a0; rdx = b0;
    @(posedge clk); @(negedge clk);
    doneAt = -1;
    for (int k = 1; k <= N + 8; k++) begin
      rda = $urandom; rdx = $urandom;
      @(posedge clk); @(negedge clk);
      if (done) begin
        doneAt = k;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    checkOutput("rerequest_latency", 64'(doneAt), 64'(N));
    @(posedge clk); @(negedge clk);
    prod = (2*N)'(a0) * (2*N)'(b0);
    checkOutput("rerequest_hi", 64'(Hi), 64'(prod[2*N-1:N]));
    checkOutput("rerequest_lo", 64'(Lo), 64'(prod[N-1:0]));
    @(posedge clk); @(negedge clk);
    checkOutput("rerequest_not_queued", 64'(busy), 64'd0);
    mHi = prod[2*N-1:N]; mLo = prod[N-1:0];

    // Reset at iteration 20 of a DIV, after div_zero has been set
    runAndCheck(OP_DIV, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1, 1);
    start = 1'b1; alu_decode = OP_DIV; rda = 32'd1000; rdx = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_hi", 64'(Hi), 64'd0);
    checkOutput("midreset_lo", 64'(Lo), 64'd0);
    checkOutput("midreset_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDone(N + 4, pulses);
    checkOutput("midreset_no_done", 64'(pulses), 64'd0);
    checkOutput("midreset_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
